// File: rtl/time_keeper_pkg.sv
// time_keeper_pkg
//   Shared widths, limits and the 11-bit {hour, min} time-field layout used
//   by the time keeper and the alarm block, plus small helpers.
package time_keeper_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int TIME_W = HOUR_W + MIN_W;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

  // Time field layout: hour in the upper 5 bits, minutes in the lower 6.
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
  } time_t;

  // Which source updates the counters this cycle, in priority order.
  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_LOAD,
    UPD_SET,
    UPD_TICK
  } upd_e;

  // Increment with wrap to zero; ">=" also recovers any out-of-range value.
  function automatic logic [5:0] incWrap(input logic [5:0] value,
                                         input logic [5:0] maxValue);
    return (value >= maxValue) ? 6'd0 : value + 6'd1;
  endfunction

  function automatic logic timeValid(input time_t t);
    return (t.hour <= HOUR_MAX) && (t.min <= MIN_MAX);
  endfunction

endpackage

// File: rtl/time_keeper_tick.sv
// tick_gen
//   Prescaler counting 0..TICKS_PER_SEC-1 while enabled; tick is high in
//   the cycle whose clock edge wraps the count back to 0.
//   Ports: clk, rst (async active-low), en (count enable),
//          clr (synchronous clear, wins over en), tick (wrap pulse).
module tick_gen #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_MAX);

  // Next count: clear wins, otherwise advance only while enabled so a
  // disabled period holds the partial second.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// time_keeper
//   Hour/minute/second clock with load and setting buttons.
//   Ports: clk, rst (async active-low), en (run enable), load + load_time
//          ({hour, min}), inc_min, inc_hour, time_out ({hour, min}),
//          sec_out, sec_tick (seconds advanced by counting),
//          min_tick (minutes advanced by seconds carry).
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [TIME_W-1:0] load_time,
  input  logic              inc_min,
  input  logic              inc_hour,
  output logic [TIME_W-1:0] time_out,
  output logic [SEC_W-1:0]  sec_out,
  output logic              sec_tick,
  output logic              min_tick
);

  logic [HOUR_W-1:0] hour_q, hour_d;
  logic [MIN_W-1:0]  min_q,  min_d;
  logic [SEC_W-1:0]  sec_q,  sec_d;
  logic              secTick_q, secTick_d;
  logic              minTick_q, minTick_d;

  time_t loadT;
  logic  loadValid;
  logic  tick;
  upd_e  updSel;

  assign loadT     = load_time;
  assign loadValid = load && timeValid(loadT);

  // A valid load also restarts the second, so the prescaler is cleared.
  tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (loadValid),
    .tick(tick)
  );

  // Pick the single winning update source; a tick that collides with a
  // load or a button press is dropped.
  always_comb begin
    updSel = UPD_NONE;
    if (loadValid) begin
      updSel = UPD_LOAD;
    end else if (inc_min || inc_hour) begin
      updSel = UPD_SET;
    end else if (tick) begin
      updSel = UPD_TICK;
    end
  end

  // Next-state for the time counters and the registered tick pulses.
  always_comb begin
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    secTick_d = 1'b0;
    minTick_d = 1'b0;
    case (updSel)
      UPD_LOAD: begin
        hour_d = loadT.hour;
        min_d  = loadT.min;
        sec_d  = '0;
      end
      UPD_SET: begin
        if (inc_min) begin
          min_d = incWrap(min_q, MIN_MAX);
          sec_d = '0;
        end
        if (inc_hour) begin
          hour_d = (hour_q >= HOUR_MAX) ? '0 : hour_q + 1'b1;
        end
      end
      UPD_TICK: begin
        secTick_d = 1'b1;
        sec_d     = incWrap(sec_q, SEC_MAX);
        if (sec_q >= SEC_MAX) begin
          minTick_d = 1'b1;
          min_d     = incWrap(min_q, MIN_MAX);
          if (min_q >= MIN_MAX) begin
            hour_d = (hour_q >= HOUR_MAX) ? '0 : hour_q + 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Time and pulse registers; these drive the outputs directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      secTick_q <= 1'b0;
      minTick_q <= 1'b0;
    end else begin
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      secTick_q <= secTick_d;
      minTick_q <= minTick_d;
    end
  end

  assign time_out = {hour_q, min_q};
  assign sec_out  = sec_q;
  assign sec_tick = secTick_q;
  assign min_tick = minTick_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper
//   Directed, table-driven bench for time_keeper with TICKS_PER_SEC=10,
//   plus a hand-written asynchronous reset sequence.
module tb_time_keeper;
  import time_keeper_pkg::*;

  localparam int TPS = 10;

  logic              clk;
  logic              rst;
  logic              en;
  logic              load;
  logic [TIME_W-1:0] loadTime;
  logic              incMin;
  logic              incHour;
  logic [TIME_W-1:0] timeOut;
  logic [SEC_W-1:0]  secOut;
  logic              secTick;
  logic              minTick;

  int checkCount;
  int missCount;
  int secTickSeen;
  int minTickSeen;

  typedef struct {
    logic              en;
    logic              load;
    logic [TIME_W-1:0] loadTime;
    logic              incMin;
    logic              incHour;
    int                cycles;
    logic [TIME_W-1:0] expTime;
    int                expSec;
    int                expSecTicks;
    int                expMinTicks;
  } vec_t;

  vec_t vecs[$];

  time_keeper #(
    .TICKS_PER_SEC(TPS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_time(loadTime),
    .inc_min  (incMin),
    .inc_hour (incHour),
    .time_out (timeOut),
    .sec_out  (secOut),
    .sec_tick (secTick),
    .min_tick (minTick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [TIME_W-1:0] hm(input int h, input int m);
    return {5'(h), 6'(m)};
  endfunction

  function automatic vec_t mk(input logic e, input logic ld,
                              input logic [TIME_W-1:0] lt, input logic im,
                              input logic ih, input int cyc,
                              input logic [TIME_W-1:0] et, input int es,
                              input int st, input int mt);
    vec_t v;
    v.en = e; v.load = ld; v.loadTime = lt; v.incMin = im; v.incHour = ih;
    v.cycles = cyc; v.expTime = et; v.expSec = es;
    v.expSecTicks = st; v.expMinTicks = mt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called at a negedge; requests are single-cycle and dropped after one edge.
  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      load    = 1'b0;
      incMin  = 1'b0;
      incHour = 1'b0;
      if (secTick) secTickSeen++;
      if (minTick) minTickSeen++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    secTickSeen = 0;
    minTickSeen = 0;
    en       = v.en;
    load     = v.load;
    loadTime = v.loadTime;
    incMin   = v.incMin;
    incHour  = v.incHour;
    runCycles(v.cycles);
  endtask

  initial begin
    checkCount = 0;
    missCount  = 0;
    rst      = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    loadTime = '0;
    incMin   = 1'b0;
    incHour  = 1'b0;

    //               en ld loadTime   im ih cyc   expTime     sec sT mT
    vecs.push_back(mk(1, 0, hm(0, 0),  0, 0, 600, hm(0, 1),    0, 60, 1));
    vecs.push_back(mk(1, 1, hm(23, 59),0, 0, 601, hm(0, 0),    0, 60, 1));
    vecs.push_back(mk(1, 0, hm(0, 0),  0, 0, 35,  hm(0, 0),    3,  3, 0));
    vecs.push_back(mk(1, 1, hm(24, 5), 0, 0, 3,   hm(0, 0),    3,  0, 0));
    vecs.push_back(mk(1, 1, hm(1, 60), 0, 0, 2,   hm(0, 0),    4,  1, 0));
    vecs.push_back(mk(1, 1, hm(8, 59), 0, 0, 1,   hm(8, 59),   0,  0, 0));
    vecs.push_back(mk(1, 0, hm(0, 0),  0, 0, 25,  hm(8, 59),   2,  2, 0));
    vecs.push_back(mk(1, 0, hm(0, 0),  1, 0, 1,   hm(8, 0),    0,  0, 0));
    vecs.push_back(mk(1, 1, hm(23, 15),0, 0, 1,   hm(23, 15),  0,  0, 0));
    vecs.push_back(mk(1, 0, hm(0, 0),  0, 1, 1,   hm(0, 15),   0,  0, 0));
    vecs.push_back(mk(1, 1, hm(10, 59),0, 0, 1,   hm(10, 59),  0,  0, 0));
    vecs.push_back(mk(1, 0, hm(0, 0),  1, 1, 1,   hm(11, 0),   0,  0, 0));
    vecs.push_back(mk(1, 1, hm(12, 30),0, 0, 1,   hm(12, 30),  0,  0, 0));
    vecs.push_back(mk(1, 0, hm(0, 0),  0, 0, 599, hm(12, 30), 59, 59, 0));
    vecs.push_back(mk(1, 1, hm(12, 30),0, 0, 1,   hm(12, 30),  0,  0, 0));
    vecs.push_back(mk(1, 0, hm(0, 0),  0, 0, 4,   hm(12, 30),  0,  0, 0));
    vecs.push_back(mk(0, 0, hm(0, 0),  0, 0, 50,  hm(12, 30),  0,  0, 0));
    vecs.push_back(mk(1, 0, hm(0, 0),  0, 0, 5,   hm(12, 30),  0,  0, 0));
    vecs.push_back(mk(1, 0, hm(0, 0),  0, 0, 1,   hm(12, 30),  1,  1, 0));
    vecs.push_back(mk(0, 1, hm(5, 6),  0, 0, 1,   hm(5, 6),    0,  0, 0));
    vecs.push_back(mk(0, 0, hm(0, 0),  1, 0, 1,   hm(5, 7),    0,  0, 0));
    vecs.push_back(mk(0, 0, hm(0, 0),  0, 1, 1,   hm(6, 7),    0,  0, 0));
    vecs.push_back(mk(1, 0, hm(0, 0),  0, 0, 9,   hm(6, 7),    0,  0, 0));
    vecs.push_back(mk(1, 0, hm(0, 0),  0, 1, 1,   hm(7, 7),    0,  0, 0));
    vecs.push_back(mk(1, 0, hm(0, 0),  0, 0, 9,   hm(7, 7),    0,  0, 0));
    vecs.push_back(mk(1, 0, hm(0, 0),  0, 0, 1,   hm(7, 7),    1,  1, 0));

    // Reset state, then release on a falling edge.
    repeat (3) @(negedge clk);
    checkOutput("reset time", int'(timeOut), 0);
    checkOutput("reset sec", int'(secOut), 0);
    checkOutput("reset sec_tick", int'(secTick), 0);
    checkOutput("reset min_tick", int'(minTick), 0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d time", i), int'(timeOut), int'(vecs[i].expTime));
      checkOutput($sformatf("v%0d sec", i), int'(secOut), vecs[i].expSec);
      checkOutput($sformatf("v%0d sec_ticks", i), secTickSeen, vecs[i].expSecTicks);
      checkOutput($sformatf("v%0d min_ticks", i), minTickSeen, vecs[i].expMinTicks);
    end

    // Mid-count asynchronous reset: 07:07:01 with prescaler at 0, run 13
    // cycles to reach sec 2 with a partial second of 3 counts.
    en = 1'b1;
    runCycles(13);
    checkOutput("pre-reset sec", int'(secOut), 2);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset time", int'(timeOut), 0);
    checkOutput("async reset sec", int'(secOut), 0);
    checkOutput("async reset sec_tick", int'(secTick), 0);
    checkOutput("async reset min_tick", int'(minTick), 0);
    load     = 1'b1;
    loadTime = hm(7, 7);
    incMin   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("load in reset time", int'(timeOut), 0);
    load   = 1'b0;
    incMin = 1'b0;
    rst    = 1'b1;
    secTickSeen = 0;
    minTickSeen = 0;
    runCycles(9);
    checkOutput("post-reset 9 sec", int'(secOut), 0);
    checkOutput("post-reset 9 ticks", secTickSeen, 0);
    runCycles(1);
    checkOutput("post-reset 10 sec", int'(secOut), 1);
    checkOutput("post-reset 10 ticks", secTickSeen, 1);
    checkOutput("post-reset time", int'(timeOut), 0);

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100_000_000: clk cycles per second (use 10 in simulation).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en  input  1  run enable; 0 freezes prescaler and time counters.
REQ-005 SHALL have port load  input  1  single-cycle request to load load_time.
REQ-006 SHALL have port load_time  input  11  {hour[4:0], min[5:0]} value to load.
REQ-007 SHALL have port inc_min  input  1  single-cycle minute-advance request (setting buttons).
REQ-008 SHALL have port inc_hour  input  1  single-cycle hour-advance request.
REQ-009 SHALL have port time_out  output  11  {hour[4:0], min[5:0]}, directly feeds the alarm block time input.
REQ-010 SHALL have port sec_out  output  6  current seconds, 0-59.
REQ-011 SHALL have port sec_tick  output  1  one-cycle pulse when seconds advance by counting.
REQ-012 SHALL have port min_tick  output  1  one-cycle pulse when minutes advance by seconds carry.

Function
REQ-013 Prescaler SHALL count 0..TICKS_PER_SEC-1 while en=1 and emit an internal tick on the cycle it wraps to 0.
REQ-014 On tick, seconds SHALL increment, wrapping 59->0; wrap SHALL carry into minutes (59->0), and minute wrap SHALL carry into hours (23->0); 23:59:59 + tick -> 00:00:00.
REQ-015 sec_tick SHALL assert in the cycle after the tick-driven update is registered, exactly one cycle per second; min_tick likewise on seconds carry only.
REQ-016 Outputs SHALL be registered; time_out/sec_out reflect the update one cycle after the triggering tick or request.
REQ-017 load with hour<=23 and min<=59 SHALL set hour/min from load_time, clear seconds and prescaler to 0; no sec_tick/min_tick for that cycle.
REQ-018 load with hour>23 or min>59 SHALL be ignored entirely (no state change).
REQ-019 inc_min SHALL advance minutes by 1 (59->0) without carry into hours and SHALL clear seconds; inc_hour SHALL advance hours by 1 (23->0) with minutes unchanged.
REQ-020 inc_min and inc_hour in the same cycle SHALL both apply.
REQ-021 Priority SHALL be load > inc_min/inc_hour > tick; a tick coinciding with load or inc is discarded (prescaler still wraps, no ticks pulsed).
REQ-022 load, inc_min, inc_hour SHALL act regardless of en.
REQ-023 en=0 SHALL hold prescaler value; resuming continues from the held count.
REQ-024 Counters SHALL never hold out-of-range values (hour>23, min>59, sec>59) in any sequence.

Reset
REQ-025 rst low SHALL asynchronously force prescaler=0, hour=0, min=0, sec=0, sec_tick=0, min_tick=0.
REQ-026 Reset mid-count SHALL discard partial second; first tick after release occurs TICKS_PER_SEC enabled cycles later.
REQ-027 Reset release SHALL be synchronous to clk for internal state use (no load/inc acted on in the release cycle's edge if rst low at that edge).

Structure
REQ-028 Shared package SHALL hold HOUR_W=5, MIN_W=6, SEC_W=6, HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59 and the 11-bit time-field layout, also used by the alarm block.
REQ-029 Prescaler SHALL be one sub-module, tick_gen (parameter TICKS_PER_SEC, ports clk, rst, en, clr, tick).

Verification (TICKS_PER_SEC=10)
REQ-030 Reset, en=1, run 600 cycles -> time_out=00:01, sec_out=0, exactly 60 sec_tick and 1 min_tick pulses.
REQ-031 load 23:59, then 600 enabled cycles -> time_out=00:00, sec_out=0, min_tick pulses once at wrap.
REQ-032 load_time hour=24 or min=60 -> time_out unchanged, seconds/prescaler unchanged.
REQ-033 time 08:59, inc_min -> 08:00, sec_out=0; inc_hour at 23:xx -> 00:xx; both together at 10:59 -> 11:00.
REQ-034 load asserted in same cycle as internal tick at 12:30:59 -> 12:30 (load value) with sec=0, no min_tick.
REQ-035 en=0 for 50 cycles mid-second, rst pulsed low mid-count -> counters frozen while disabled; all outputs 0 immediately on rst, next tick 10 enabled cycles after release.
